ime_sad_scan_ctrl: RTL and testbench

Full-search IME scheduler placed in front of the 16-PE 4x4 SAD array and its 16x16 adder tree. It raster-walks every integer MV candidate in a ±SR window and issues one candidate per handshake to the reference fetch / PE enable. It tracks each issued candidate through the fixed-latency SAD pipeline. It reports the minimum macroblock SAD and its MV when the scan completes.

---
 rtl/ime_sad_scan_ctrl_pkg.sv | 10 +
 rtl/ime_sad_scan_ctrl_if.sv | 33 +++
 rtl/ime_sad_scan_tag_pipe.sv | 52 +++++
 rtl/ime_sad_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_ime_sad_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ime_sad_scan_ctrl_pkg.sv
// Shared IME constants for the integer-motion-estimation full-search scheduler.
// The top-level parameters default to these values.
package ime_sad_scan_ctrl_pkg;

    localparam int IME_SR         = 16;
    localparam int IME_SAD_MB_LEN = 16;
    localparam int IME_LAT        = 3;
    localparam int IME_MV_W       = 6;

endpackage

// File: rtl/ime_sad_scan_ctrl_if.sv
// Bundle between the IME scheduler, the reference fetch/PE array, and the SAD adder tree.
// The slave view belongs to the scheduler. The master view belongs to whoever drives it.
interface ime_sad_scan_ctrl_if
    import ime_sad_scan_ctrl_pkg::*;
#(
    parameter int SAD_W = IME_SAD_MB_LEN,
    parameter int MV_W  = IME_MV_W
);
    logic                    start_i;
    logic                    ref_ready_i;
    logic [SAD_W-1:0]        sad_i;
    logic                    ref_req_o;
    logic signed [MV_W-1:0]  ref_mvx_o;
    logic signed [MV_W-1:0]  ref_mvy_o;
    logic                    pe_enable_o;
    logic                    busy_o;
    logic                    done_o;
    logic [SAD_W-1:0]        best_sad_o;
    logic signed [MV_W-1:0]  best_mvx_o;
    logic signed [MV_W-1:0]  best_mvy_o;

    modport slave (
        input  start_i, ref_ready_i, sad_i,
        output ref_req_o, ref_mvx_o, ref_mvy_o, pe_enable_o,
               busy_o, done_o, best_sad_o, best_mvx_o, best_mvy_o
    );

    modport master (
        output start_i, ref_ready_i, sad_i,
        input  ref_req_o, ref_mvx_o, ref_mvy_o, pe_enable_o,
               busy_o, done_o, best_sad_o, best_mvx_o, best_mvy_o
    );
endinterface

// File: rtl/ime_sad_scan_tag_pipe.sv
// This is the fixed-latency {valid, mvx, mvy} tag line that runs alongside the SAD pipeline.
// It never stalls, because the PEs behind it have no stall.
module ime_tag_pipe #(
    parameter int LAT  = 3,
    parameter int MV_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    input  logic signed [MV_W-1:0] in_mvx_i,
    input  logic signed [MV_W-1:0] in_mvy_i,
    output logic                   out_valid_o,
    output logic signed [MV_W-1:0] out_mvx_o,
    output logic signed [MV_W-1:0] out_mvy_o,
    output logic                   pending_o
);
    logic [LAT-1:0]         valid_q;
    logic signed [MV_W-1:0] mvx_q [LAT];
    logic signed [MV_W-1:0] mvy_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                mvx_q[i] <= '0;
                mvy_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            mvx_q[0]   <= in_mvx_i;
            mvy_q[0]   <= in_mvy_i;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                mvx_q[i]   <= mvx_q[i-1];
                mvy_q[i]   <= mvy_q[i-1];
            end
        end
    end

    // pending_o: the pipe will still hold a valid tag next cycle; the last stage is leaving now
    always_comb begin
        pending_o = in_valid_i;
        for (int i = 0; i < LAT - 1; i++) begin
            pending_o = pending_o | valid_q[i];
        end
    end

    assign out_valid_o = valid_q[LAT-1];
    assign out_mvx_o   = mvx_q[LAT-1];
    assign out_mvy_o   = mvy_q[LAT-1];

endmodule

// File: rtl/ime_sad_scan_ctrl.sv
// Full-search IME scheduler. It raster-walks the +/-SR window, issues candidates to the SAD array,
// and keeps the minimum SAD and its MV.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_i; best_* hold the last result
// ST_SCAN  | ref_req_o high; one candidate issued per ref_ready_i cycle
// ST_DRAIN | all candidates issued; waiting for the tag pipe to empty
// ST_DONE  | single cycle; done_o high, best_* just loaded
module ime_sad_scan_ctrl
    import ime_sad_scan_ctrl_pkg::*;
#(
    parameter int SR    = IME_SR,
    parameter int LAT   = IME_LAT,
    parameter int SAD_W = IME_SAD_MB_LEN,
    parameter int MV_W  = IME_MV_W
) (
    input  logic                 clk,
    input  logic                 rst,
    ime_sad_scan_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic signed [MV_W-1:0] MV_LO = MV_W'(-SR);
    localparam logic signed [MV_W-1:0] MV_HI = MV_W'(SR - 1);

    state_e                 state_q, state_d;
    logic signed [MV_W-1:0] mvx_q, mvx_d, mvy_q, mvy_d;
    logic [SAD_W-1:0]       run_sad_q, run_sad_d;
    logic signed [MV_W-1:0] run_mvx_q, run_mvx_d, run_mvy_q, run_mvy_d;
    logic [SAD_W-1:0]       best_sad_q, best_sad_d;
    logic signed [MV_W-1:0] best_mvx_q, best_mvx_d, best_mvy_q, best_mvy_d;

    logic                   issue;
    logic                   last_cand;
    logic                   tag_valid;
    logic signed [MV_W-1:0] tag_mvx, tag_mvy;
    logic                   pipe_pending;

    assign issue     = (state_q == ST_SCAN) && bus.ref_ready_i;
    assign last_cand = (mvx_q == MV_HI) && (mvy_q == MV_HI);

    ime_tag_pipe #(
        .LAT  (LAT),
        .MV_W (MV_W)
    ) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (issue),
        .in_mvx_i    (mvx_q),
        .in_mvy_i    (mvy_q),
        .out_valid_o (tag_valid),
        .out_mvx_o   (tag_mvx),
        .out_mvy_o   (tag_mvy),
        .pending_o   (pipe_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mvx_q      <= '0;
            mvy_q      <= '0;
            run_sad_q  <= '1;
            run_mvx_q  <= '0;
            run_mvy_q  <= '0;
            best_sad_q <= '1;
            best_mvx_q <= '0;
            best_mvy_q <= '0;
        end else begin
            state_q    <= state_d;
            mvx_q      <= mvx_d;
            mvy_q      <= mvy_d;
            run_sad_q  <= run_sad_d;
            run_mvx_q  <= run_mvx_d;
            run_mvy_q  <= run_mvy_d;
            best_sad_q <= best_sad_d;
            best_mvx_q <= best_mvx_d;
            best_mvy_q <= best_mvy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mvx_d      = mvx_q;
        mvy_d      = mvy_q;
        run_sad_d  = run_sad_q;
        run_mvx_d  = run_mvx_q;
        run_mvy_d  = run_mvy_q;
        best_sad_d = best_sad_q;
        best_mvx_d = best_mvx_q;
        best_mvy_d = best_mvy_q;

        // Strict compare: on a tie, the earlier candidate in raster order stays
        if (tag_valid && (bus.sad_i < run_sad_q)) begin
            run_sad_d = bus.sad_i;
            run_mvx_d = tag_mvx;
            run_mvy_d = tag_mvy;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d   = ST_SCAN;
                    mvx_d     = MV_LO;
                    mvy_d     = MV_LO;
                    run_sad_d = '1;
                    run_mvx_d = MV_LO;
                    run_mvy_d = MV_LO;
                end
            end
            ST_SCAN: begin
                if (issue) begin
                    if (last_cand) begin
                        state_d = ST_DRAIN;
                    end else if (mvx_q == MV_HI) begin
                        mvx_d = MV_LO;
                        mvy_d = mvy_q + 1'b1;
                    end else begin
                        mvx_d = mvx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // The final tag may be retiring this cycle, so best_* take the updated running values
                if (!pipe_pending) begin
                    state_d    = ST_DONE;
                    best_sad_d = run_sad_d;
                    best_mvx_d = run_mvx_d;
                    best_mvy_d = run_mvy_d;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ref_req_o   = (state_q == ST_SCAN);
    assign bus.pe_enable_o = issue;
    assign bus.ref_mvx_o   = mvx_q;
    assign bus.ref_mvy_o   = mvy_q;
    assign bus.busy_o      = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign bus.done_o      = (state_q == ST_DONE);
    assign bus.best_sad_o  = best_sad_q;
    assign bus.best_mvx_o  = best_mvx_q;
    assign bus.best_mvy_o  = best_mvy_q;

endmodule

// File: tb/tb_ime_sad_scan_ctrl.sv
// Scoreboard bench for ime_sad_scan_ctrl with SR=2. A behavioural PE/adder-tree model returns
// the SAD three cycles after each issue.
module tb_ime_sad_scan_ctrl;
    localparam int SR    = 2;
    localparam int LAT   = 3;
    localparam int SAD_W = 16;
    localparam int MV_W  = 6;

    logic clk;
    logic rst;
    int   cyc;

    ime_sad_scan_ctrl_if #(.SAD_W(SAD_W), .MV_W(MV_W)) bus ();

    ime_sad_scan_ctrl #(
        .SR    (SR),
        .LAT   (LAT),
        .SAD_W (SAD_W),
        .MV_W  (MV_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Scoreboard queues
    int exp_sad_q[$], exp_mvx_q[$], exp_mvy_q[$], exp_lat_q[$], exp_start_q[$];
    int mvq_x[$], mvq_y[$];
    int iss_cnt  = 0;
    int done_cnt = 0;
    int held_sad = 65535, held_mvx = 0, held_mvy = 0;
    bit hold_chk_en = 1'b0;

    int model_sel  = 0;
    int ready_mode = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sad_model(input int sel, input int x, input int y);
        case (sel)
            0: return iabs(x - 1) + iabs(y + 1) * 4;
            1: return ((x == 0 && y == 0) || (x == 1 && y == 1)) ? 50 : 100;
            2: return 65535;
            default: return iabs(x + 2) + iabs(y - 1);
        endcase
    endfunction

    // PE array + adder tree: sad_i in cycle k+LAT carries the candidate issued in cycle k
    int e_v [LAT];
    int e_x [LAT];
    int e_y [LAT];
    initial begin
        for (int i = 0; i < LAT; i++) begin
            e_v[i] = 0; e_x[i] = 0; e_y[i] = 0;
        end
        bus.sad_i = '0;
        forever begin
            @(negedge clk);
            bus.sad_i = (e_v[LAT-1] != 0) ? SAD_W'(sad_model(model_sel, e_x[LAT-1], e_y[LAT-1])) : '0;
            for (int i = LAT - 1; i > 0; i--) begin
                e_v[i] = e_v[i-1]; e_x[i] = e_x[i-1]; e_y[i] = e_y[i-1];
            end
            e_v[0] = int'(bus.pe_enable_o);
            e_x[0] = int'($signed(bus.ref_mvx_o));
            e_y[0] = int'($signed(bus.ref_mvy_o));
        end
    end

    // ref_ready_i: held high, or the repeating 1,0,0,1 backpressure pattern
    initial begin
        logic [3:0] patt;
        patt = 4'b1001;
        bus.ref_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.ref_ready_i = (ready_mode == 0) ? 1'b1 : patt[cyc % 4];
        end
    end

    // Monitor
    initial begin
        int es, ex, ey, el, st;
        forever begin
            @(negedge clk);
            check("pe_en_vs_req_ready", int'(bus.pe_enable_o),
                  int'(bus.ref_req_o & bus.ref_ready_i));
            if (bus.pe_enable_o) begin
                iss_cnt++;
                if (mvq_x.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    check("issue_mvx", int'($signed(bus.ref_mvx_o)), mvq_x.pop_front());
                    check("issue_mvy", int'($signed(bus.ref_mvy_o)), mvq_y.pop_front());
                end
            end
            if (bus.done_o) begin
                done_cnt++;
                if (exp_sad_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    es = exp_sad_q.pop_front();
                    ex = exp_mvx_q.pop_front();
                    ey = exp_mvy_q.pop_front();
                    el = exp_lat_q.pop_front();
                    st = exp_start_q.pop_front();
                    check("best_sad", int'(bus.best_sad_o), es);
                    check("best_mvx", int'($signed(bus.best_mvx_o)), ex);
                    check("best_mvy", int'($signed(bus.best_mvy_o)), ey);
                    check("issue_count", iss_cnt, (2 * SR) * (2 * SR));
                    check("busy_in_done", int'(bus.busy_o), 0);
                    check("req_in_done", int'(bus.ref_req_o), 0);
                    if (el >= 0) check("done_latency", cyc - st, el);
                    held_sad = es; held_mvx = ex; held_mvy = ey;
                end
                iss_cnt = 0;
            end else if (hold_chk_en) begin
                check("hold_sad", int'(bus.best_sad_o), held_sad);
                check("hold_mvx", int'($signed(bus.best_mvx_o)), held_mvx);
                check("hold_mvy", int'($signed(bus.best_mvy_o)), held_mvy);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        check({tag, "_req"},   int'(bus.ref_req_o), 0);
        check({tag, "_pe"},    int'(bus.pe_enable_o), 0);
        check({tag, "_busy"},  int'(bus.busy_o), 0);
        check({tag, "_done"},  int'(bus.done_o), 0);
        check({tag, "_mvx"},   int'($signed(bus.ref_mvx_o)), 0);
        check({tag, "_mvy"},   int'($signed(bus.ref_mvy_o)), 0);
        check({tag, "_bsad"},  int'(bus.best_sad_o), 65535);
        check({tag, "_bmvx"},  int'($signed(bus.best_mvx_o)), 0);
        check({tag, "_bmvy"},  int'($signed(bus.best_mvy_o)), 0);
    endtask

    // Called at posedge+1; it leaves the stimulus at posedge+1 one cycle later
    task automatic start_scan(input int model, input int rmode, input int es,
                              input int ex, input int ey, input int elat);
        model_sel  = model;
        ready_mode = rmode;
        for (int y = -SR; y < SR; y++) begin
            for (int x = -SR; x < SR; x++) begin
                mvq_x.push_back(x);
                mvq_y.push_back(y);
            end
        end
        exp_sad_q.push_back(es);
        exp_mvx_q.push_back(ex);
        exp_mvy_q.push_back(ey);
        exp_lat_q.push_back(elat);
        exp_start_q.push_back(cyc);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int prev;
        int n;
        prev = done_cnt;
        n = 0;
        while (done_cnt == prev && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", int'(done_cnt != prev), 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int d0;
        int n;
        rst = 1'b1;
        bus.start_i = 1'b0;
        idle_cycles(3);
        chk_reset_outputs("reset");
        rst = 1'b0;
        held_sad = 65535; held_mvx = 0; held_mvy = 0;
        hold_chk_en = 1'b1;
        idle_cycles(2);

        // Basic scan, ready held high
        start_scan(0, 0, 0, 1, -1, (2 * SR) * (2 * SR) + LAT + 1);
        wait_done(200);
        idle_cycles(3);

        // Ties: the first 50 in raster order wins
        start_scan(1, 0, 50, 0, 0, (2 * SR) * (2 * SR) + LAT + 1);
        wait_done(200);
        idle_cycles(3);

        // Backpressure 1,0,0,1
        start_scan(0, 1, 0, 1, -1, -1);
        wait_done(400);
        idle_cycles(3);

        // All-ones SAD; a second start pulse in SCAN is ignored
        d0 = done_cnt;
        start_scan(2, 0, 65535, -2, -2, (2 * SR) * (2 * SR) + LAT + 1);
        idle_cycles(4);
        bus.start_i = 1'b1;
        idle_cycles(1);
        bus.start_i = 1'b0;
        wait_done(200);
        idle_cycles(30);
        check("single_done", done_cnt - d0, 1);

        // Reset at issue 7 aborts the scan
        d0 = done_cnt;
        start_scan(0, 0, 0, 1, -1, -1);
        n = 0;
        while (iss_cnt < 7 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_issue7", int'(iss_cnt >= 7), 1);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        exp_sad_q.delete(); exp_mvx_q.delete(); exp_mvy_q.delete();
        exp_lat_q.delete(); exp_start_q.delete();
        mvq_x.delete(); mvq_y.delete();
        iss_cnt = 0;
        held_sad = 65535; held_mvx = 0; held_mvy = 0;
        chk_reset_outputs("abort");
        idle_cycles(25);
        check("no_done_after_abort", done_cnt - d0, 0);

        start_scan(0, 0, 0, 1, -1, (2 * SR) * (2 * SR) + LAT + 1);
        wait_done(200);
        idle_cycles(3);

        // Back-to-back scans with different models
        start_scan(3, 0, 0, -2, 1, (2 * SR) * (2 * SR) + LAT + 1);
        wait_done(200);
        start_scan(0, 0, 0, 1, -1, (2 * SR) * (2 * SR) + LAT + 1);
        wait_done(200);
        idle_cycles(5);

        check("queues_drained", exp_sad_q.size() + mvq_x.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
